// File: rtl/carbon_uart_tx_serializer.sv
// UART transmit serializer with a circular byte FIFO and a sticky overflow flag.
// Define CARBON_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module carbon_uart_tx_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [7:0]                        in_byte,
    input  logic                              ovf_clr,
    output logic                              txd,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

`ifdef CARBON_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic            txd_q, txd_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            empty, full, push, pop, drop, bit_end;
    logic [7:0]      head;
    logic [2:0]      idx_nx;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign head    = mem_q[rptr_q];
    assign bit_end = (cnt_q == '0);
    assign idx_nx  = idx_q + 3'd1;

    // A full FIFO still accepts a byte when the serializer pops in the same cycle.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && !push;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    cnt_d   = RELOAD;
                    sh_d    = head;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = RELOAD;
                    idx_d   = '0;
                    txd_d   = sh_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = RELOAD;
                    if (idx_q == 3'd7) begin
`ifdef CARBON_UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = ^sh_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d = idx_nx;
                        txd_d = sh_q[idx_nx];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef CARBON_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = RELOAD;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                        cnt_d   = RELOAD;
                        sh_d    = head;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // A drop in the same cycle as a clear wins so no overflow goes unseen.
    assign ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_byte;
    end

    assign txd        = txd_q;
    assign busy       = !empty || (state_q != IDLE);
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_carbon_uart_tx_serializer.sv
// Directed bench for carbon_uart_tx_serializer: framing, latency, FIFO, overflow, reset.
// Frame length follows CARBON_UART_TX_PARITY_EN when it is defined.
module tb_carbon_uart_tx_serializer;

`ifdef CARBON_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid4, ovf_clr4, txd4, busy4, ovf4;
    logic [7:0] in_byte4;
    logic [4:0] lvl4;
    logic       in_valid2, ovf_clr2, txd2, busy2, ovf2;
    logic [7:0] in_byte2;
    logic [4:0] lvl2;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] q[$];
    logic [7:0] nb;

    always #5 clk = ~clk;

    carbon_uart_tx_serializer #(.CLK_DIV(4), .FIFO_DEPTH(16)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_byte(in_byte4),
        .ovf_clr(ovf_clr4), .txd(txd4), .busy(busy4), .fifo_level(lvl4),
        .overflow(ovf4)
    );

    carbon_uart_tx_serializer #(.CLK_DIV(2), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_byte(in_byte2),
        .ovf_clr(ovf_clr2), .txd(txd2), .busy(busy2), .fifo_level(lvl2),
        .overflow(ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Sample one frame from bit-sample offset 'first'; optionally push on u4
    // so that the push lands on the edge that ends STOP.
    task automatic frame(input int u, input logic [7:0] b, input int first,
                         input bit pe, input logic [7:0] pb, input string tag);
        for (int s = first; s < FB * u; s++) begin
            chk($sformatf("%s txd s%0d", tag, s), (u == 2) ? txd2 : txd4, fbit(b, s / u));
            chk($sformatf("%s busy s%0d", tag, s), (u == 2) ? busy2 : busy4, 1);
            if (pe && s == FB * u - 1) begin
                in_valid4 = 1'b1;
                in_byte4  = pb;
            end
            tick();
            in_valid4 = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid4 = 1'b0; in_byte4 = '0; ovf_clr4 = 1'b0;
        in_valid2 = 1'b0; in_byte2 = '0; ovf_clr2 = 1'b0;
        tick();
        tick();
        chk("rst txd", txd4, 1);
        chk("rst busy", busy4, 0);
        chk("rst level", lvl4, 0);
        chk("rst ovf", ovf4, 0);
        rst_n = 1'b1;
        tick();

        // 0xA5, single frame, latency and busy duration
        in_valid4 = 1'b1; in_byte4 = 8'hA5;
        tick();
        in_valid4 = 1'b0;
        chk("lat txd", txd4, 1);
        chk("lat level", lvl4, 1);
        chk("lat busy", busy4, 1);
        tick();
        frame(4, 8'hA5, 0, 1'b0, 8'h00, "a5");
        chk("a5 busy end", busy4, 0);
        chk("a5 txd end", txd4, 1);
        chk("a5 level end", lvl4, 0);

        // 0x01, then a push into the empty FIFO on the STOP-ending edge
        in_valid4 = 1'b1; in_byte4 = 8'h01;
        tick();
        in_valid4 = 1'b0;
        tick();
        frame(4, 8'h01, 0, 1'b1, 8'h3C, "x01");
        chk("stopend txd", txd4, 1);
        chk("stopend level", lvl4, 1);
        chk("stopend busy", busy4, 1);
        tick();
        frame(4, 8'h3C, 0, 1'b0, 8'h00, "x3c");
        chk("x3c busy end", busy4, 0);

        // back-to-back frames at CLK_DIV=2
        in_valid2 = 1'b1; in_byte2 = 8'h11;
        tick();
        in_byte2 = 8'h22;
        tick();
        in_byte2 = 8'h33;
        tick();
        in_valid2 = 1'b0;
        chk("b2b level", lvl2, 2);
        frame(2, 8'h11, 1, 1'b0, 8'h00, "b2b11");
        frame(2, 8'h22, 0, 1'b0, 8'h00, "b2b22");
        frame(2, 8'h33, 0, 1'b0, 8'h00, "b2b33");
        chk("b2b busy end", busy2, 0);
        chk("b2b txd end", txd2, 1);

        // 18 consecutive pushes: 17 accepted, last dropped
        for (int i = 0; i < 18; i++) begin
            in_valid4 = 1'b1;
            in_byte4  = 8'h40 + 8'(i);
            tick();
        end
        in_valid4 = 1'b0;
        for (int i = 1; i <= 16; i++) q.push_back(8'h40 + 8'(i));
        chk("ovf set", ovf4, 1);
        chk("ovf level", lvl4, 16);
        in_valid4 = 1'b1; in_byte4 = 8'hEE; ovf_clr4 = 1'b1;
        tick();
        in_valid4 = 1'b0; ovf_clr4 = 1'b0;
        chk("ovf clr+drop", ovf4, 1);
        chk("ovf clr+drop level", lvl4, 16);
        ovf_clr4 = 1'b1;
        tick();
        ovf_clr4 = 1'b0;
        chk("ovf clr", ovf4, 0);

        // full FIFO, push on the STOP-ending edge, then 40 more through the wrap
        frame(4, 8'h40, 18, 1'b1, 8'hC3, "x40");
        q.push_back(8'hC3);
        chk("fullpush ovf", ovf4, 0);
        chk("fullpush level", lvl4, 16);
        for (int j = 0; j < 40; j++) begin
            nb = 8'(j * 37 + 5);
            frame(4, q[0], 0, 1'b1, nb, $sformatf("wrap%0d", j));
            void'(q.pop_front());
            q.push_back(nb);
            chk($sformatf("wrap%0d level", j), lvl4, 16);
            chk($sformatf("wrap%0d ovf", j), ovf4, 0);
        end
        while (q.size() > 0) begin
            frame(4, q[0], 0, 1'b0, 8'h00, "drain");
            void'(q.pop_front());
        end
        chk("drain busy", busy4, 0);
        chk("drain level", lvl4, 0);

        // reset during DATA bit 3 of 0x5A with 4 bytes queued
        for (int i = 0; i < 5; i++) begin
            in_valid4 = 1'b1;
            in_byte4  = (i == 0) ? 8'h5A : 8'(i);
            tick();
        end
        in_valid4 = 1'b0;
        chk("mid level", lvl4, 4);
        repeat (14) tick();
        chk("mid bit3", txd4, 1);
        chk("mid busy", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("arst txd", txd4, 1);
        chk("arst level", lvl4, 0);
        chk("arst busy", busy4, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst level", lvl4, 0);
        chk("post rst busy", busy4, 0);
        in_valid4 = 1'b1; in_byte4 = 8'h5A;
        tick();
        in_valid4 = 1'b0;
        tick();
        frame(4, 8'h5A, 0, 1'b0, 8'h00, "x5a");
        chk("x5a busy end", busy4, 0);
        chk("x5a level end", lvl4, 0);
        chk("u2 ovf", ovf2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
